// File: rtl/apb_master_arb_pkg.sv
// Shared types, width defaults and the address-legality helper for the two-requester APB master.
package apb_master_arb_pkg;

    localparam int unsigned ADDR_W_DEFAULT = 32;
    localparam int unsigned DATA_W_DEFAULT = 32;

    typedef enum logic [1:0] {
        StIdle,
        StSetup,
        StAccess,
        StCapture
    } state_e;

    // Caller zero-extends the address; legal means word aligned and inside the register file.
    function automatic logic addr_ok(input logic [63:0] addr, input int unsigned num_regs);
        logic [63:0] limit;
        limit = 64'(num_regs) << 2;
        return (addr[1:0] == 2'b00) && (addr < limit);
    endfunction

endpackage

// File: rtl/apb_master_arb_if.sv
// APB bus between the master and the register-file slave (the slave has no PREADY).
interface apb_master_arb_if
    import apb_master_arb_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEFAULT,
    parameter int unsigned DATA_W = DATA_W_DEFAULT
);

    logic              PSEL;
    logic              PENABLE;
    logic              PWRITE;
    logic [ADDR_W-1:0] PADDR;
    logic [DATA_W-1:0] PWDATA;
    logic [DATA_W-1:0] PRDATA;

    modport master (
        output PSEL,
        output PENABLE,
        output PWRITE,
        output PADDR,
        output PWDATA,
        input  PRDATA
    );

    modport slave (
        input  PSEL,
        input  PENABLE,
        input  PWRITE,
        input  PADDR,
        input  PWDATA,
        output PRDATA
    );

endinterface

// File: rtl/rr_arb2.sv
// Two-input round-robin arbiter; on contention the requester not granted last time wins.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] gnt
);

    logic last_grant_q;
    logic last_grant_d;

    always_comb begin
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = last_grant_q ? 2'b01 : 2'b10;
            default: gnt = 2'b00;
        endcase
    end

    always_comb begin
        last_grant_d = last_grant_q;
        if (advance && (gnt != 2'b00)) begin
            last_grant_d = gnt[1];
        end
    end

    // Reset to 1 so requester 0 wins the first contention.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant_q <= 1'b1;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end

endmodule

// File: rtl/apb_master_arb.sv
// Two-requester APB master: round-robin grant, IDLE/SETUP/ACCESS/CAPTURE sequencing with an extra
// capture cycle for the slave's registered PRDATA, and local rejection of illegal addresses.
module apb_master_arb
    import apb_master_arb_pkg::*;
#(
    parameter int unsigned ADDR_W   = ADDR_W_DEFAULT,
    parameter int unsigned DATA_W   = DATA_W_DEFAULT,
    parameter int unsigned NUM_REGS = 4
) (
    input  logic              PCLK,
    input  logic              PRESETn,
    input  logic              req0,
    input  logic              req1,
    input  logic              wr0,
    input  logic              wr1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              done0,
    output logic              done1,
    output logic              err0,
    output logic              err1,
    output logic [DATA_W-1:0] rdata0,
    output logic [DATA_W-1:0] rdata1,
    apb_master_arb_if.master  apb
);

    state_e state_q, state_d;

    logic [1:0]        eligible;
    logic [1:0]        gnt;
    logic              gnt_sel;
    logic              sel_wr;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic              sel_ok;

    logic              cur_q, cur_d;
    logic              psel_q, psel_d;
    logic              penable_q, penable_d;
    logic              pwrite_q, pwrite_d;
    logic [ADDR_W-1:0] paddr_q, paddr_d;
    logic [DATA_W-1:0] pwdata_q, pwdata_d;
    logic [1:0]        done_q, done_d;
    logic [1:0]        err_q, err_d;
    logic [DATA_W-1:0] rdata0_q, rdata0_d;
    logic [DATA_W-1:0] rdata1_q, rdata1_d;

    // A requester whose done is showing still holds req for that one cycle, so mask it.
    assign eligible = {req1 & ~done_q[1], req0 & ~done_q[0]};

    rr_arb2 u_arb (
        .clk     (PCLK),
        .rst_n   (PRESETn),
        .req     (eligible),
        .advance (state_q == StIdle),
        .gnt     (gnt)
    );

    assign gnt_sel   = gnt[1];
    assign sel_wr    = gnt_sel ? wr1 : wr0;
    assign sel_addr  = gnt_sel ? addr1 : addr0;
    assign sel_wdata = gnt_sel ? wdata1 : wdata0;
    assign sel_ok    = addr_ok(64'(sel_addr), NUM_REGS);

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:    if ((gnt != 2'b00) && sel_ok) state_d = StSetup;
            StSetup:   state_d = StAccess;
            StAccess:  state_d = pwrite_q ? StIdle : StCapture;
            StCapture: state_d = StIdle;
            default:   state_d = StIdle;
        endcase
    end

    // Next values of the registered outputs; the bus fields double as the latched grant fields.
    always_comb begin
        cur_d     = cur_q;
        psel_d    = 1'b0;
        penable_d = 1'b0;
        pwrite_d  = pwrite_q;
        paddr_d   = paddr_q;
        pwdata_d  = pwdata_q;
        done_d    = 2'b00;
        err_d     = 2'b00;
        rdata0_d  = rdata0_q;
        rdata1_d  = rdata1_q;
        unique case (state_q)
            StIdle: begin
                if (gnt != 2'b00) begin
                    cur_d    = gnt_sel;
                    pwrite_d = sel_wr;
                    paddr_d  = sel_addr;
                    pwdata_d = sel_wdata;
                    if (sel_ok) begin
                        psel_d = 1'b1;
                    end else begin
                        done_d = gnt;
                        err_d  = gnt;
                    end
                end
            end
            StSetup: begin
                psel_d    = 1'b1;
                penable_d = 1'b1;
            end
            StAccess: begin
                if (pwrite_q) begin
                    done_d[cur_q] = 1'b1;
                end
            end
            StCapture: begin
                done_d[cur_q] = 1'b1;
                if (cur_q) begin
                    rdata1_d = apb.PRDATA;
                end else begin
                    rdata0_d = apb.PRDATA;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            cur_q     <= 1'b0;
            psel_q    <= 1'b0;
            penable_q <= 1'b0;
            pwrite_q  <= 1'b0;
            paddr_q   <= '0;
            pwdata_q  <= '0;
            done_q    <= 2'b00;
            err_q     <= 2'b00;
            rdata0_q  <= '0;
            rdata1_q  <= '0;
        end else begin
            cur_q     <= cur_d;
            psel_q    <= psel_d;
            penable_q <= penable_d;
            pwrite_q  <= pwrite_d;
            paddr_q   <= paddr_d;
            pwdata_q  <= pwdata_d;
            done_q    <= done_d;
            err_q     <= err_d;
            rdata0_q  <= rdata0_d;
            rdata1_q  <= rdata1_d;
        end
    end

    assign apb.PSEL    = psel_q;
    assign apb.PENABLE = penable_q;
    assign apb.PWRITE  = pwrite_q;
    assign apb.PADDR   = paddr_q;
    assign apb.PWDATA  = pwdata_q;
    assign done0       = done_q[0];
    assign done1       = done_q[1];
    assign err0        = err_q[0];
    assign err1        = err_q[1];
    assign rdata0      = rdata0_q;
    assign rdata1      = rdata1_q;

endmodule

// File: doc/apb_master_arb.md
Name: apb_master_arb

Overview:
- Two-requester APB master that sequences single read/write transactions into the team's 32-bit APB register-file slave (no PREADY, PRDATA registered during ACCESS).
- Arbitrates round-robin between requesters and runs the IDLE/SETUP/ACCESS protocol.
- Adds the extra capture cycle the slave's registered PRDATA requires.
- Rejects misaligned and out-of-range addresses locally, without issuing a bus cycle.

Parameters:
- ADDR_W, 32, APB address width.
- DATA_W, 32, APB data width.
- NUM_REGS, 4, number of word registers decoded by the slave; legal addresses are 0 .. 4*NUM_REGS-4.

Ports:
- PCLK  in  1  APB clock.
- PRESETn  in  1  reset, asynchronous, active-low.
- req0 / req1  in  1  transaction request from requester 0 / 1; held until its done pulse.
- wr0 / wr1  in  1  1 = write, 0 = read; stable while req is high.
- addr0 / addr1  in  ADDR_W  byte address; stable while req is high.
- wdata0 / wdata1  in  DATA_W  write data; stable while req is high.
- done0 / done1  out  1  one-cycle completion pulse.
- err0 / err1  out  1  valid with done; 1 = address rejected.
- rdata0 / rdata1  out  DATA_W  read data, valid with done on a successful read; holds its value otherwise.
- PSEL  out  1  APB select.
- PENABLE  out  1  APB enable.
- PWRITE  out  1  APB direction.
- PADDR  out  ADDR_W  APB address.
- PWDATA  out  DATA_W  APB write data.
- PRDATA  in  DATA_W  APB read data from the slave.

Behaviour:
- Reset (async, PRESETn=0):
  - All outputs are 0 and FSM = IDLE.
  - last_grant = 1, so requester 0 wins the first contention.
  - Asserting reset mid-transaction aborts it immediately: no done pulse, PSEL/PENABLE drop in the same cycle.
- All outputs are registered.
- FSM states: IDLE, SETUP, ACCESS, CAPTURE.
- Masking in IDLE: a requester whose done is high in that cycle is ignored, because its req is still high for one cycle.
- Arbitration in IDLE:
  - eligible_i = req_i & ~done_i.
  - Exactly one eligible: grant it.
  - Both eligible: grant ~last_grant; last_grant updates on each grant.
  - Grant-time fields (gnt, wr, addr, wdata) are latched into registers; PADDR/PWRITE/PWDATA load from them at the same edge.
- Address check in IDLE on the granted request:
  - Error if addr[1:0] != 0 or addr >= 4*NUM_REGS.
  - On error: stay in IDLE, pulse done_g with err_g=1 next cycle, rdata_g unchanged, no PSEL.
- Otherwise IDLE -> SETUP.
- SETUP: PSEL=1, PENABLE=0, PADDR/PWRITE/PWDATA stable. Always -> ACCESS.
- ACCESS: PSEL=1, PENABLE=1.
  - Write: -> IDLE, with done_g=1, err_g=0 in the next cycle.
  - Read: -> CAPTURE.
- CAPTURE: PSEL=0, PENABLE=0. At the exiting edge: rdata_g <= PRDATA, done_g=1. Then -> IDLE.
- PADDR/PWRITE/PWDATA hold their last values in IDLE (no toggling); PSEL=0 in IDLE.
- Latency, with req first eligible in IDLE cycle T:
  - Write: SETUP T+1, ACCESS T+2, done T+3.
  - Read: done + rdata T+4.
  - Error: done + err T+1.
- Back-to-back: the IDLE cycle carrying done for one requester may grant the other, giving a new SETUP the following cycle with no dead cycle beyond IDLE.
- A requester dropping req before done is a protocol violation; the transaction still completes and done still pulses.
- done0 and done1 are never high together.

Decomposition:
- Package apb_master_arb_pkg holds:
  - the state enum (IDLE, SETUP, ACCESS, CAPTURE);
  - the ADDR_W/DATA_W defaults;
  - the function addr_ok(addr, NUM_REGS).
- One sub-module, rr_arb2: two-input round-robin arbiter with inputs req[1:0], advance, and a registered last_grant; output gnt[1:0] (one-hot or zero). Reset last_grant = 1.
- The FSM and datapath stay in the top level.

Test Plan:
- Reset, then req0 read addr 0x4 -> PSEL/PENABLE sequence 10, 11, 00; done0 at T+4 with rdata0=0xA5A5_0000, err0=0.
- req1 write 0x8 = 0xDEAD_BEEF, then req1 read 0x8 -> write done1 at T+3; read rdata1=0xDEAD_BEEF; PWRITE=1 and PWDATA=0xDEAD_BEEF during SETUP/ACCESS of the write.
- req0 and req1 both read 0xC in the same cycle, held through completion -> order 0, 1, 0 alternating; each rdata=0x5A5A_5555; second SETUP one cycle after the first done.
- req0 addr 0x6 (misaligned) and req1 addr 0x10 (out of range) -> done with err=1 one cycle after grant; PSEL never asserted; rdata unchanged.
- PRESETn pulled low during ACCESS of a write to 0x0 -> PSEL/PENABLE/done immediately 0; after release, read 0x0 returns 0x0000_0000 (slave reset), and the next contention grants req0.
